// File: rtl/table_mp_pkg.sv
// Shared types and helpers for the multi-port lookup table.
// Latency: not applicable (types, constants and pure functions only).
// Backpressure: not applicable.
package table_mp_pkg;

    // Upper bound on TABLE_SIZE that the popcount helper accepts.
    localparam int MAX_TABLE_SIZE = 4096;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Index width for a table of 'size' entries.
    function automatic int index_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Counts set bits in the low 'n' positions of v.
    function automatic int unsigned popcount(input logic [MAX_TABLE_SIZE-1:0] v,
                                             input int unsigned n);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < n && i < MAX_TABLE_SIZE; i++) begin
            c += 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/table_mp_clr_fsm.sv
// Bulk-clear sequencer: walks every table index once and clears it.
// Latency: busy from the cycle after clr_req for exactly TABLE_SIZE cycles; done pulses as busy drops.
// Backpressure: none; clr_req while busy is ignored.
// Ports: clk/rst (sync, active-high), clr_req in; clr_busy, clr_done, clr_we, clr_idx out.
module table_mp_clr_fsm
    import table_mp_pkg::*;
#(
    parameter  int TABLE_SIZE  = 32,
    localparam int INDEX_WIDTH = index_width(TABLE_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   clr_we,
    output logic [INDEX_WIDTH-1:0] clr_idx
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(TABLE_SIZE - 1);

    clr_state_t             state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic                   done_q, done_d;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                // The last entry is cleared this cycle; done shows up together
                // with busy falling on the next cycle.
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        clr_busy = (state_q == CLEAR);
        clr_we   = (state_q == CLEAR);
        clr_idx  = cnt_q;
        clr_done = done_q;
    end

endmodule

// File: rtl/table_mp.sv
// Multi-port lookup table with per-entry valid bits, hit flags, bulk clear and occupancy count.
// Latency: write visible the next cycle; reads registered, exactly 1 cycle.
// Backpressure: none; while a clear runs, writes are dropped and reads return no strobe.
// Ports: clk/rst; wr_en/index_wr/data_wr write ports; rd_en/index_rd read requests;
//        data_rd/rd_vld/rd_hit read responses; clr_req/clr_busy/clr_done clear control; valid_cnt.
module table_mp
    import table_mp_pkg::*;
#(
    parameter  int TABLE_SIZE  = 32,
    parameter  int DATA_WIDTH  = 8,
    parameter  int INPUT_RATE  = 2,
    parameter  int OUTPUT_RATE = 2,
    parameter  int RD_MODE     = 0,
    localparam int INDEX_WIDTH = index_width(TABLE_SIZE),
    localparam int CNT_WIDTH   = $clog2(TABLE_SIZE + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [INPUT_RATE-1:0]             wr_en,
    input  logic [INPUT_RATE*INDEX_WIDTH-1:0] index_wr,
    input  logic [INPUT_RATE*DATA_WIDTH-1:0]  data_wr,
    input  logic [OUTPUT_RATE-1:0]            rd_en,
    input  logic [OUTPUT_RATE*INDEX_WIDTH-1:0] index_rd,
    output logic [OUTPUT_RATE*DATA_WIDTH-1:0] data_rd,
    output logic [OUTPUT_RATE-1:0]            rd_vld,
    output logic [OUTPUT_RATE-1:0]            rd_hit,
    input  logic                              clr_req,
    output logic                              clr_busy,
    output logic                              clr_done,
    output logic [CNT_WIDTH-1:0]              valid_cnt
);

    // One extra bit so the range check is meaningful for power-of-two sizes too.
    localparam logic [INDEX_WIDTH:0] SIZE_EXT = (INDEX_WIDTH + 1)'(TABLE_SIZE);

    logic                   clr_we;
    logic [INDEX_WIDTH-1:0] clr_idx;

    logic [DATA_WIDTH-1:0]  mem_q [TABLE_SIZE];
    logic [DATA_WIDTH-1:0]  mem_d [TABLE_SIZE];
    logic [TABLE_SIZE-1:0]  valid_q, valid_d;

    logic [INDEX_WIDTH-1:0] w_idx [INPUT_RATE];
    logic [DATA_WIDTH-1:0]  w_dat [INPUT_RATE];
    logic [INPUT_RATE-1:0]  w_ok;

    logic [OUTPUT_RATE*DATA_WIDTH-1:0] rd_dat_q, rd_dat_d;
    logic [OUTPUT_RATE-1:0]            rd_vld_q, rd_vld_d;
    logic [OUTPUT_RATE-1:0]            rd_hit_q, rd_hit_d;

    table_mp_clr_fsm #(
        .TABLE_SIZE (TABLE_SIZE)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    // Unpack write ports and qualify them: in range and no clear running.
    always_comb begin
        for (int p = 0; p < INPUT_RATE; p++) begin
            w_idx[p] = index_wr[p*INDEX_WIDTH +: INDEX_WIDTH];
            w_dat[p] = data_wr[p*DATA_WIDTH +: DATA_WIDTH];
            w_ok[p]  = wr_en[p] && !clr_busy && ({1'b0, w_idx[p]} < SIZE_EXT);
        end
    end

    // Storage update. Ports are applied in ascending order so the
    // highest-numbered port overrides lower ones on a collision.
    // Clear steps and port writes are mutually exclusive by construction.
    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        if (clr_we) begin
            mem_d[clr_idx]   = '0;
            valid_d[clr_idx] = 1'b0;
        end
        for (int p = 0; p < INPUT_RATE; p++) begin
            if (w_ok[p]) begin
                mem_d[w_idx[p]]   = w_dat[p];
                valid_d[w_idx[p]] = 1'b1;
            end
        end
    end

    // Storage contents are intentionally not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Read response. Idle ports hold their last data/hit.
    always_comb begin
        logic [INDEX_WIDTH-1:0] r_idx;
        r_idx    = '0;
        rd_dat_d = rd_dat_q;
        rd_hit_d = rd_hit_q;
        rd_vld_d = '0;
        for (int q = 0; q < OUTPUT_RATE; q++) begin
            r_idx = index_rd[q*INDEX_WIDTH +: INDEX_WIDTH];
            if (rd_en[q] && !clr_busy) begin
                rd_vld_d[q] = 1'b1;
                if ({1'b0, r_idx} >= SIZE_EXT) begin
                    rd_dat_d[q*DATA_WIDTH +: DATA_WIDTH] = '0;
                    rd_hit_d[q]                          = 1'b0;
                end else begin
                    rd_dat_d[q*DATA_WIDTH +: DATA_WIDTH] = mem_q[r_idx];
                    rd_hit_d[q]                          = valid_q[r_idx];
                    // Write-through: forward the winning (last matching) port.
                    if (RD_MODE == 1) begin
                        for (int p = 0; p < INPUT_RATE; p++) begin
                            if (w_ok[p] && (w_idx[p] == r_idx)) begin
                                rd_dat_d[q*DATA_WIDTH +: DATA_WIDTH] = w_dat[p];
                                rd_hit_d[q]                          = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_q <= '0;
            rd_vld_q <= '0;
            rd_hit_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
            rd_vld_q <= rd_vld_d;
            rd_hit_q <= rd_hit_d;
        end
    end

    assign data_rd   = rd_dat_q;
    assign rd_vld    = rd_vld_q;
    assign rd_hit    = rd_hit_q;
    assign valid_cnt = CNT_WIDTH'(popcount(MAX_TABLE_SIZE'(valid_q), TABLE_SIZE));

endmodule
